// File: rtl/br_counter_incr_coalescer_if.sv
// Event-in / increment-out bundle for br_counter_incr_coalescer.
//   in_valid, in_count : event beat from the producer (master -> slave)
//   in_ready           : beat acceptance (slave -> master)
//   incr_valid, incr   : registered increment pulse toward br_counter_incr (slave -> master)
// The coalescer uses the slave modport; the producer/observer side uses master.
interface br_counter_incr_coalescer_if #(
   parameter int unsigned MaxIncrement  = 4,
   parameter int unsigned MaxEventCount = 2
);
   localparam int unsigned CountWidth     = $clog2(MaxEventCount + 1);
   localparam int unsigned IncrementWidth = $clog2(MaxIncrement + 1);

   logic                      in_valid;
   logic                      in_ready;
   logic [CountWidth-1:0]     in_count;
   logic                      incr_valid;
   logic [IncrementWidth-1:0] incr;

   modport master (
      output in_valid,
      output in_count,
      input  in_ready,
      input  incr_valid,
      input  incr
   );

   modport slave (
      input  in_valid,
      input  in_count,
      output in_ready,
      output incr_valid,
      output incr
   );
endinterface

// File: rtl/br_counter_incr_coalescer.sv
// Coalesces a ready/valid stream of small per-cycle event counts into a pending sum and
// emits registered incr_valid/incr pulses, each 1..MaxIncrement, for br_counter_incr.
// Ports:
//   clk, rst : single clock, synchronous active-high reset
//   bus      : slave side of the event/increment interface
//   flush    : level; emit any nonzero pending sum every cycle while high
//   hold     : level; suppress all emission while high (wins over flush)
//   pending  : current accumulator value
//   idle     : nothing pending and no pulse in flight
module br_counter_incr_coalescer #(
   parameter int unsigned MaxIncrement  = 4,
   parameter int unsigned MaxEventCount = 2,
   parameter int unsigned MaxPending    = 8,
   parameter int unsigned FlushTimeout  = 3
) (
   input  logic                             clk,
   input  logic                             rst,
   br_counter_incr_coalescer_if.slave       bus,
   input  logic                             flush,
   input  logic                             hold,
   output logic [$clog2(MaxPending+1)-1:0]  pending,
   output logic                             idle
);

   localparam int unsigned CountWidth     = $clog2(MaxEventCount + 1);
   localparam int unsigned IncrementWidth = $clog2(MaxIncrement + 1);
   localparam int unsigned PendingWidth   = $clog2(MaxPending + 1);
   localparam int unsigned AgeWidth       = $clog2(FlushTimeout) + 1;

   localparam logic [PendingWidth-1:0] MaxIncP   = PendingWidth'(MaxIncrement);
   localparam logic [PendingWidth-1:0] ReadyMax  = PendingWidth'(MaxPending - MaxEventCount);
   localparam logic [PendingWidth-1:0] MaxPendP  = PendingWidth'(MaxPending);
   localparam logic [AgeWidth-1:0]     AgeMax    = AgeWidth'(FlushTimeout - 1);
   localparam logic [CountWidth-1:0]   MaxCountC = CountWidth'(MaxEventCount);

   logic [PendingWidth-1:0]   pending_q, pending_d;
   logic [AgeWidth-1:0]       age_q, age_d;
   logic                      incr_valid_q;
   logic [IncrementWidth-1:0] incr_q;
   logic [PendingWidth-1:0]   amt;
   logic                      emit;
   logic                      ready;
   logic                      accept;

   always_comb begin
      // Headroom check on registered state only, so a full beat always fits.
      ready  = !rst && (pending_q <= ReadyMax);
      accept = bus.in_valid && ready;

      emit = !hold && (pending_q != '0) &&
             ((pending_q >= MaxIncP) || (age_q >= AgeMax) || flush);

      amt = '0;
      if (emit) begin
         amt = (pending_q >= MaxIncP) ? MaxIncP : pending_q;
      end

      pending_d = pending_q - amt;
      if (accept) begin
         pending_d = pending_d + PendingWidth'(bus.in_count);
      end

      // Age measures how long the current residue has waited since the last pulse.
      age_d = age_q;
      if (emit || (pending_q == '0)) begin
         age_d = '0;
      end else if (age_q < AgeMax) begin
         age_d = age_q + AgeWidth'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pending_q    <= '0;
         age_q        <= '0;
         incr_valid_q <= 1'b0;
         incr_q       <= '0;
      end else begin
         pending_q    <= pending_d;
         age_q        <= age_d;
         incr_valid_q <= emit;
         incr_q       <= IncrementWidth'(amt);
      end
   end

   assign bus.in_ready   = ready;
   assign bus.incr_valid = incr_valid_q;
   assign bus.incr       = incr_q;
   assign pending        = pending_q;
   assign idle           = (pending_q == '0) && !incr_valid_q;

   in_count_range_a : assert property (@(posedge clk) disable iff (rst)
      bus.in_valid |-> (bus.in_count <= MaxCountC));

   in_count_stable_a : assert property (@(posedge clk) disable iff (rst)
      (bus.in_valid && !ready) |=> $stable(bus.in_count));

   pending_range_a : assert property (@(posedge clk) disable iff (rst)
      pending_q <= MaxPendP);

endmodule

// File: tb/tb_br_counter_incr_coalescer.sv
module tb_br_counter_incr_coalescer;

   localparam int MaxIncrement  = 4;
   localparam int MaxEventCount = 2;
   localparam int MaxPending    = 8;
   localparam int FlushTimeout  = 3;
   localparam int CountWidth    = $clog2(MaxEventCount + 1);

   logic       clk = 1'b0;
   logic       rst;
   logic       flush;
   logic       hold;
   logic [3:0] pending;
   logic       idle;

   always #5 clk = ~clk;

   br_counter_incr_coalescer_if #(
      .MaxIncrement  (MaxIncrement),
      .MaxEventCount (MaxEventCount)
   ) bus_if ();

   br_counter_incr_coalescer #(
      .MaxIncrement  (MaxIncrement),
      .MaxEventCount (MaxEventCount),
      .MaxPending    (MaxPending),
      .FlushTimeout  (FlushTimeout)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .bus     (bus_if.slave),
      .flush   (flush),
      .hold    (hold),
      .pending (pending),
      .idle    (idle)
   );

   int n_assert = 0;
   int n_fail   = 0;

   // Reference model state, in plain integers.
   int m_pending = 0;
   int m_age     = 0;
   int m_incr    = 0;
   bit m_iv      = 1'b0;
   bit last_acc  = 1'b0;
   int acc_sum   = 0;
   int emit_sum  = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // One clock: predict from the rules, advance, then compare every output.
   task automatic step();
      bit rdy;
      bit acc;
      bit emit;
      int amt;
      int cnt;
      int next_age;
      rdy  = !rst && (m_pending <= MaxPending - MaxEventCount);
      acc  = bus_if.in_valid && rdy;
      cnt  = int'(bus_if.in_count);
      emit = !hold && (m_pending > 0) &&
             (m_pending >= MaxIncrement || m_age >= FlushTimeout - 1 || flush);
      amt  = emit ? ((m_pending < MaxIncrement) ? m_pending : MaxIncrement) : 0;
      if (emit || m_pending == 0) next_age = 0;
      else next_age = (m_age + 1 > FlushTimeout - 1) ? FlushTimeout - 1 : m_age + 1;
      @(posedge clk);
      #1;
      if (rst) begin
         m_pending = 0;
         m_age     = 0;
         m_iv      = 1'b0;
         m_incr    = 0;
         acc_sum   = 0;
         emit_sum  = 0;
         last_acc  = 1'b0;
      end else begin
         m_pending = m_pending - amt + (acc ? cnt : 0);
         m_age     = next_age;
         m_iv      = emit;
         m_incr    = amt;
         last_acc  = acc;
         if (acc) acc_sum += cnt;
         if (bus_if.incr_valid === 1'b1) emit_sum += int'(bus_if.incr);
      end
      check("model_pending", pending, m_pending);
      check("model_incr_valid", bus_if.incr_valid, m_iv);
      check("model_incr", bus_if.incr, m_incr);
      check("model_in_ready", bus_if.in_ready,
            (!rst && m_pending <= MaxPending - MaxEventCount) ? 1 : 0);
      check("model_idle", idle, (m_pending == 0 && !m_iv) ? 1 : 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      flush = 1'b0;
      hold = 1'b0;
      bus_if.in_valid = 1'b0;
      bus_if.in_count = '0;

      // Reset state
      step();
      step();
      check("rst_in_ready", bus_if.in_ready, 0);
      check("rst_incr_valid", bus_if.incr_valid, 0);
      check("rst_pending", pending, 0);
      rst = 1'b0;
      #1;
      check("ready_after_rst", bus_if.in_ready, 1);
      step();
      check("idle_after_rst", idle, 1);

      // Single event, timeout flush
      bus_if.in_valid = 1'b1;
      bus_if.in_count = CountWidth'(1);
      step();
      bus_if.in_valid = 1'b0;
      check("to_pending_t1", pending, 1);
      step();
      step();
      check("to_pending_t3", pending, 1);
      check("to_no_pulse_t3", bus_if.incr_valid, 0);
      step();
      check("to_pulse_t4", bus_if.incr_valid, 1);
      check("to_incr_t4", bus_if.incr, 1);
      step();
      check("to_idle_t5", idle, 1);

      // Threshold
      bus_if.in_valid = 1'b1;
      bus_if.in_count = CountWidth'(2);
      step();
      step();
      bus_if.in_valid = 1'b0;
      check("th_pending", pending, 4);
      step();
      check("th_pulse", bus_if.incr_valid, 1);
      check("th_incr", bus_if.incr, 4);
      check("th_drained", pending, 0);
      step();
      step();
      check("th_no_more", bus_if.incr_valid, 0);

      // Simultaneous accept and emit
      bus_if.in_valid = 1'b1;
      bus_if.in_count = CountWidth'(2);
      step();
      step();
      check("sim_pending4", pending, 4);
      step();
      bus_if.in_valid = 1'b0;
      check("sim_incr", bus_if.incr, 4);
      check("sim_residue", pending, 2);
      step();
      check("sim_wait1", bus_if.incr_valid, 0);
      step();
      check("sim_wait2", bus_if.incr_valid, 0);
      step();
      check("sim_timeout_pulse", bus_if.incr_valid, 1);
      check("sim_timeout_incr", bus_if.incr, 2);
      step();

      // Flush
      bus_if.in_valid = 1'b1;
      bus_if.in_count = CountWidth'(2);
      step();
      bus_if.in_count = CountWidth'(1);
      step();
      bus_if.in_valid = 1'b0;
      check("fl_pending3", pending, 3);
      flush = 1'b1;
      step();
      flush = 1'b0;
      check("fl_pulse", bus_if.incr_valid, 1);
      check("fl_incr", bus_if.incr, 3);
      check("fl_drained", pending, 0);
      step();
      flush = 1'b1;
      step();
      step();
      flush = 1'b0;
      check("fl_empty_no_pulse", bus_if.incr_valid, 0);

      // Hold with backpressure
      hold = 1'b1;
      bus_if.in_valid = 1'b1;
      bus_if.in_count = CountWidth'(2);
      for (int k = 1; k <= 4; k++) begin
         step();
         check("hold_pending", pending, 2 * k);
      end
      check("hold_ready_low", bus_if.in_ready, 0);
      step();
      step();
      check("hold_suppressed", bus_if.incr_valid, 0);
      check("hold_pending_full", pending, 8);
      bus_if.in_valid = 1'b0;
      hold = 1'b0;
      step();
      check("hold_rel_incr1", bus_if.incr, 4);
      check("hold_ready_back", bus_if.in_ready, 1);
      step();
      check("hold_rel_incr2", bus_if.incr, 4);
      check("hold_rel_empty", pending, 0);
      step();
      check("hold_conserve", emit_sum, acc_sum);

      // Reset mid-operation
      hold = 1'b1;
      bus_if.in_valid = 1'b1;
      bus_if.in_count = CountWidth'(2);
      step();
      step();
      bus_if.in_count = CountWidth'(1);
      step();
      bus_if.in_valid = 1'b0;
      check("rm_pending5", pending, 5);
      hold = 1'b0;
      step();
      check("rm_pulse", bus_if.incr_valid, 1);
      check("rm_residue", pending, 1);
      rst = 1'b1;
      #1;
      check("rm_ready_in_rst", bus_if.in_ready, 0);
      step();
      rst = 1'b0;
      check("rm_iv_cleared", bus_if.incr_valid, 0);
      check("rm_pending_cleared", pending, 0);
      for (int k = 0; k < 5; k++) begin
         step();
         check("rm_no_pulse", bus_if.incr_valid, 0);
      end

      // Randomized traffic against the model
      for (int i = 0; i < 600; i++) begin
         if (!(bus_if.in_valid && !last_acc)) begin
            bus_if.in_valid = ($urandom_range(0, 3) != 0);
            bus_if.in_count = CountWidth'($urandom_range(0, MaxEventCount));
         end
         flush = ($urandom_range(0, 9) == 0);
         hold  = ($urandom_range(0, 4) == 0);
         rst   = ($urandom_range(0, 99) == 0);
         step();
      end

      // Drain and confirm conservation
      rst = 1'b0;
      flush = 1'b0;
      hold = 1'b0;
      bus_if.in_valid = 1'b0;
      for (int i = 0; i < 20; i++) step();
      check("drain_idle", idle, 1);
      check("rand_conserve", emit_sum, acc_sum);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
